// File: rtl/mem_arb_pkg.sv
// Shared types and width derivations for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int unsigned calc_lsb(input int unsigned axi_width);
    return $clog2(axi_width) - 3;
  endfunction

  function automatic int unsigned calc_aw(input int unsigned addr_width,
                                          input int unsigned axi_width);
    return addr_width - calc_lsb(axi_width);
  endfunction

  // A single-beat maximum still needs a 1-bit length field.
  function automatic int unsigned calc_lw(input int unsigned max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

  function automatic int unsigned calc_ow(input int unsigned n_rd);
    return $clog2(n_rd + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned OW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [OW-1:0] last_i,
  output logic [OW-1:0] pick_o,
  output logic          valid_o
);

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!valid_o && req_i[j] && (j == (32'(last_i) + off) % N)) begin
          valid_o = 1'b1;
          pick_o  = OW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: N_RD burst readers plus one burst writer,
// round-robin burst ownership with one arbitration cycle between bursts.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AXI_WIDTH         = 128,
  parameter int unsigned AXI_ADDR_WIDTH    = 32,
  parameter int unsigned N_RD              = 3,
  parameter int unsigned AXI_MAX_BURST_LEN = 16,
  localparam int unsigned AW = calc_aw(AXI_ADDR_WIDTH, AXI_WIDTH),
  localparam int unsigned LW = calc_lw(AXI_MAX_BURST_LEN),
  localparam int unsigned OW = calc_ow(N_RD),
  localparam int unsigned SW = AXI_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_RD-1:0]      rd_req,
  input  logic [N_RD*AW-1:0]   rd_addr,
  input  logic [N_RD*LW-1:0]   rd_len,
  output logic [N_RD-1:0]      rd_gnt,
  output logic [AXI_WIDTH-1:0] rd_data,
  output logic [N_RD-1:0]      rd_dvalid,
  input  logic                 wr_req,
  input  logic [AW-1:0]        wr_addr,
  input  logic [LW-1:0]        wr_len,
  input  logic [AXI_WIDTH-1:0] wr_data,
  input  logic [SW-1:0]        wr_strb,
  output logic                 wr_gnt,
  output logic                 ram_ren,
  output logic                 ram_wen,
  output logic [AW-1:0]        ram_addr,
  output logic [AXI_WIDTH-1:0] ram_wdata,
  output logic [SW-1:0]        ram_strb,
  input  logic [AXI_WIDTH-1:0] ram_rdata,
  output logic                 busy,
  output logic [OW-1:0]        owner
);

  localparam int unsigned   NR     = N_RD + 1;
  localparam logic [OW-1:0] WR_IDX = OW'(N_RD);

  arb_state_e    state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic [OW-1:0] tag_q;
  logic          tag_vld_q;

  logic [NR-1:0] req_all;
  logic [OW-1:0] pick;
  logic          pick_vld;
  logic          owner_req;
  logic [AW-1:0] owner_addr;
  logic [LW-1:0] pick_len;

  assign req_all = {wr_req, rd_req};

  rr_arbiter #(
    .N  (NR),
    .OW (OW)
  ) u_rr (
    .req_i   (req_all),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_vld)
  );

  // Owner's request/address and the candidate's length; writer sits at index N_RD.
  always_comb begin
    owner_req  = 1'b0;
    owner_addr = '0;
    pick_len   = '0;
    for (int unsigned i = 0; i < N_RD; i++) begin
      if (owner_q == OW'(i)) begin
        owner_req  = rd_req[i];
        owner_addr = rd_addr[i*AW +: AW];
      end
      if (pick == OW'(i)) begin
        pick_len = rd_len[i*LW +: LW];
      end
    end
    if (owner_q == WR_IDX) begin
      owner_req  = wr_req;
      owner_addr = wr_addr;
    end
    if (pick == WR_IDX) begin
      pick_len = wr_len;
    end
  end

  // Next state and RAM-side outputs; a beat only happens in BURST with the owner requesting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rd_gnt    = '0;
    wr_gnt    = 1'b0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_strb  = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          cnt_d   = pick_len;
          state_d = BURST;
        end
      end
      BURST: begin
        if (owner_req) begin
          ram_addr = owner_addr;
          if (owner_q == WR_IDX) begin
            wr_gnt    = 1'b1;
            ram_wen   = 1'b1;
            ram_wdata = wr_data;
            ram_strb  = wr_strb;
          end else begin
            ram_ren = 1'b1;
            for (int unsigned i = 0; i < N_RD; i++) begin
              rd_gnt[i] = (owner_q == OW'(i));
            end
          end
          if (cnt_q == '0) begin
            state_d = IDLE;
            last_d  = owner_q;
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= '0;
      last_q    <= WR_IDX;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      tag_q     <= owner_q;
      tag_vld_q <= ram_ren;
    end
  end

  // RAM read data returns one cycle after ram_ren, tagged with the reader that issued it.
  always_comb begin
    rd_dvalid = '0;
    for (int unsigned i = 0; i < N_RD; i++) begin
      rd_dvalid[i] = tag_vld_q && (tag_q == OW'(i));
    end
  end

  assign rd_data = ram_rdata;
  assign busy    = (state_q == BURST);
  assign owner   = busy ? owner_q : '0;

endmodule
